// File: rtl/exu_alu_core_pkg.sv
// ----------------------------------------------------------------------------
// exu_alu_core_pkg
//   Shared definitions for the execute-stage ALU: datapath and funct widths,
//   the ALU funct codes driven by the operand-select stage, and the state
//   encoding of the multi-cycle ALU controller.
// ----------------------------------------------------------------------------
package exu_alu_core_pkg;

    localparam int ISA_WIDTH       = 32;
    localparam int ALU_FUNCT_WIDTH = 4;
    localparam int ALU_STATE_WIDTH = 2;

    // Funct codes shared with the operand-select stage. Codes 4'hB..4'hF are
    // undefined and produce a zero result.
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_NO_FUNCT  = 4'h0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD       = 4'h1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB       = 4'h2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_EQ        = 4'h3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_NEQ       = 4'h4;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_LESS_U    = 4'h5;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND       = 4'h6;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR        = 4'h7;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR       = 4'h8;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SHIFT_L_L = 4'h9;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SHIFT_R_A = 4'hA;

    typedef enum logic [ALU_STATE_WIDTH-1:0] {
        ALU_ST_IDLE  = 2'd0,
        ALU_ST_SHIFT = 2'd1,
        ALU_ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_funct(input logic [ALU_FUNCT_WIDTH-1:0] f);
        return (f == ALU_SHIFT_L_L) || (f == ALU_SHIFT_R_A);
    endfunction

endpackage

// File: rtl/exu_alu_core_shifter.sv
// ----------------------------------------------------------------------------
// exu_alu_shifter
//   Shift unit of the execute-stage ALU.
//   Default build: iterative shifter holding an accumulator and a remaining
//   count. 'load' captures a/shamt/direction, each 'step' cycle shifts the
//   accumulator by one bit; 'last' flags the step that performs the final
//   shift, with 'result' carrying the value after that shift.
//   ALU_BARREL_SHIFT_EN defined: purely combinational barrel shifter, 'result'
//   is a shifted by shamt directly; clk/rst/load/step are ignored and 'last'
//   is tied low.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   load   in   capture a, shamt and arith (iterative build)
//   step   in   perform one shift step (iterative build)
//   arith  in   1 = arithmetic right shift, 0 = logical left shift
//   a      in   WIDTH       operand to shift
//   shamt  in   SHAMT_WIDTH shift amount
//   result out  WIDTH       shifted value
//   last   out  final iterative step is happening this cycle
// ----------------------------------------------------------------------------
module exu_alu_shifter #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   step,
    input  logic                   arith,
    input  logic [WIDTH-1:0]       a,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic [WIDTH-1:0]       result,
    output logic                   last
);

`ifdef ALU_BARREL_SHIFT_EN

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] sra_s;
    logic                    unused_ok;

    // The arithmetic shift is kept in its own signed expression; mixing it
    // into the ternary with the unsigned left shift would turn it logical.
    assign a_s       = a;
    assign sra_s     = a_s >>> shamt;
    assign result    = arith ? sra_s : (a << shamt);
    assign last      = 1'b0;
    assign unused_ok = &{1'b0, clk, rst, load, step};

`else

    logic [WIDTH-1:0]       acc;
    logic [SHAMT_WIDTH-1:0] cnt;
    logic                   arith_q;

    // One-bit shift of the accumulator in the captured direction.
    assign result = arith_q ? {acc[WIDTH-1], acc[WIDTH-1:1]}
                            : {acc[WIDTH-2:0], 1'b0};
    assign last   = step && (cnt == SHAMT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            cnt     <= '0;
            arith_q <= 1'b0;
        end else if (load) begin
            acc     <= a;
            cnt     <= shamt;
            arith_q <= arith;
        end else if (step && (cnt != '0)) begin
            acc <= result;
            cnt <= cnt - SHAMT_WIDTH'(1);
        end
    end

`endif

endmodule

// File: rtl/exu_alu_core.sv
// ----------------------------------------------------------------------------
// exu_alu_core
//   Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
//   Logic, arithmetic and compare ops complete in one cycle. Shifts run one
//   bit per cycle through exu_alu_shifter (latency shamt+1), unless the
//   build macro ALU_BARREL_SHIFT_EN is defined, in which case shifts are
//   combinational and also complete in one cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  core can accept operands
//   alu_a      in   WIDTH        operand A
//   alu_b      in   WIDTH        operand B / shift amount in low SHAMT_WIDTH bits
//   alu_funct  in   FUNCT_WIDTH  operation code
//   out_valid  out  alu_result valid
//   out_ready  in   consumer accepts the result
//   alu_result out  WIDTH        registered result
//   busy       out  controller not idle
//
// Build option: ALU_BARREL_SHIFT_EN (single-cycle barrel shifts).
// ----------------------------------------------------------------------------
module exu_alu_core
    import exu_alu_core_pkg::*;
#(
    parameter int WIDTH       = ISA_WIDTH,
    parameter int FUNCT_WIDTH = ALU_FUNCT_WIDTH,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       alu_a,
    input  logic [WIDTH-1:0]       alu_b,
    input  logic [FUNCT_WIDTH-1:0] alu_funct,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       alu_result,
    output logic                   busy
);

    alu_state_e             state;
    alu_state_e             state_nxt;
    logic                   accept;
    logic                   res_load;
    logic [WIDTH-1:0]       res_nxt;
    logic                   sh_load;
    logic                   sh_step;
    logic                   sh_last;
    logic [WIDTH-1:0]       sh_result;
    logic [SHAMT_WIDTH-1:0] shamt;

    // Single-cycle ops. Shift codes never reach this function's result path;
    // they fall into the zero default along with undefined codes.
    function automatic logic [WIDTH-1:0] alu_op(
        input logic [FUNCT_WIDTH-1:0] f,
        input logic [WIDTH-1:0]       a,
        input logic [WIDTH-1:0]       b
    );
        logic [WIDTH-1:0] r;
        case (f)
            ALU_ADD:    r = a + b;
            ALU_SUB:    r = a - b;
            ALU_AND:    r = a & b;
            ALU_OR:     r = a | b;
            ALU_XOR:    r = a ^ b;
            ALU_EQ:     r = {{(WIDTH-1){1'b0}}, (a == b)};
            ALU_NEQ:    r = {{(WIDTH-1){1'b0}}, (a != b)};
            ALU_LESS_U: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default:    r = '0;
        endcase
        return r;
    endfunction

    assign shamt     = alu_b[SHAMT_WIDTH-1:0];
    assign in_ready  = (state == ALU_ST_IDLE) || ((state == ALU_ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ALU_ST_DONE);
    assign busy      = (state != ALU_ST_IDLE);
    assign sh_step   = (state == ALU_ST_SHIFT);

    exu_alu_shifter #(
        .WIDTH       (WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (sh_load),
        .step   (sh_step),
        .arith  (alu_funct == ALU_SHIFT_R_A),
        .a      (alu_a),
        .shamt  (shamt),
        .result (sh_result),
        .last   (sh_last)
    );

    // Next-state / result-load decode
    always_comb begin
        state_nxt = state;
        res_load  = 1'b0;
        res_nxt   = '0;
        sh_load   = 1'b0;
        case (state)
            ALU_ST_IDLE, ALU_ST_DONE: begin
                // A retiring result with no new op returns to IDLE; an
                // accept in the same cycle overrides this below, so DONE
                // chains straight into the next op.
                if (state == ALU_ST_DONE && out_ready) begin
                    state_nxt = ALU_ST_IDLE;
                end
                if (accept) begin
                    if (is_shift_funct(alu_funct)) begin
`ifdef ALU_BARREL_SHIFT_EN
                        res_load  = 1'b1;
                        res_nxt   = sh_result;
                        state_nxt = ALU_ST_DONE;
`else
                        sh_load = 1'b1;
                        if (shamt == '0) begin
                            res_load  = 1'b1;
                            res_nxt   = alu_a;
                            state_nxt = ALU_ST_DONE;
                        end else begin
                            state_nxt = ALU_ST_SHIFT;
                        end
`endif
                    end else begin
                        res_load  = 1'b1;
                        res_nxt   = alu_op(alu_funct, alu_a, alu_b);
                        state_nxt = ALU_ST_DONE;
                    end
                end
            end
            ALU_ST_SHIFT: begin
                if (sh_last) begin
                    res_load  = 1'b1;
                    res_nxt   = sh_result;
                    state_nxt = ALU_ST_DONE;
                end
            end
            default: state_nxt = ALU_ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ALU_ST_IDLE;
            alu_result <= '0;
        end else begin
            state <= state_nxt;
            if (res_load) begin
                alu_result <= res_nxt;
            end
        end
    end

endmodule

// File: tb/tb_exu_alu_core.sv
// ----------------------------------------------------------------------------
// tb_exu_alu_core
//   Scoreboard bench for exu_alu_core. The driver pushes the expected result
//   and expected latency for every accepted op; the monitor checks handshake
//   outputs and results every cycle against that queue.
// ----------------------------------------------------------------------------
module tb_exu_alu_core;
    import exu_alu_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_funct;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        busy;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        int          pcyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    exu_alu_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the instruction semantics.
    function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned      sh;
        logic signed [31:0] s;
        logic signed [31:0] r;
        sh = b % 32;
        s  = a;
        case (f)
            ALU_ADD:       return a + b;
            ALU_SUB:       return a - b;
            ALU_AND:       return a & b;
            ALU_OR:        return a | b;
            ALU_XOR:       return a ^ b;
            ALU_EQ:        return (a == b) ? 32'd1 : 32'd0;
            ALU_NEQ:       return (a != b) ? 32'd1 : 32'd0;
            ALU_LESS_U:    return (a < b) ? 32'd1 : 32'd0;
            ALU_SHIFT_L_L: return a << sh;
            ALU_SHIFT_R_A: begin
                r = s >>> sh;
                return r;
            end
            default:       return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] f, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((f == ALU_SHIFT_L_L || f == ALU_SHIFT_R_A) && (b % 32) != 0)
            return (b % 32) + 1;
        return 1;
`endif
    endfunction

    // Call at posedge+1. Returns the cycle stamp at which the op was accepted.
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int pc);
        int waited;
        bit done;
        exp_t e;
        waited    = 0;
        done      = 1'b0;
        pc        = -1;
        in_valid  = 1'b1;
        alu_funct = f;
        alu_a     = a;
        alu_b     = b;
        while (!done) begin
            @(negedge clk);
            #2;
            if (in_ready) begin
                e.exp  = model(f, a, b);
                e.lat  = model_lat(f, b);
                e.pcyc = cyc;
                sbq.push_back(e);
                pc   = cyc;
                done = 1'b1;
            end else if (++waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles", waited);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        alu_funct = 4'($urandom);
        alu_a     = $urandom;
        alu_b     = $urandom;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d results still pending after %0d cycles", name, sbq.size(), n);
            sbq.delete();
        end
    endtask

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: expected handshake state derives from the scoreboard head.
    always @(negedge clk) begin
        if (mon_en) begin
            bit presented;
            presented = (sbq.size() > 0) && ((cyc - sbq[0].pcyc) >= sbq[0].lat);
            chk("out_valid", 32'(out_valid), 32'(presented));
            chk("busy", 32'(busy), 32'(sbq.size() > 0));
            chk("in_ready", 32'(in_ready), 32'((sbq.size() == 0) || (presented && out_ready)));
            if (out_valid && presented) begin
                chk("alu_result", alu_result, sbq[0].exp);
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1, p2, pc;
        logic [3:0]  f;
        logic [31:0] a, b;

        rst       = 1'b0;
        in_valid  = 1'b0;
        alu_a     = 32'h0;
        alu_b     = 32'h0;
        alu_funct = ALU_NO_FUNCT;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_alu_result", alu_result, 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;

        // Basic ops with out_ready held high
        ready_mode = 1;
        issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, pc);
        issue(ALU_SUB, 32'd5, 32'd7, pc);
        issue(ALU_LESS_U, 32'h1, 32'hFFFF_FFFF, pc);
        issue(ALU_EQ, 32'd3, 32'd3, pc);
        issue(ALU_NEQ, 32'd3, 32'd3, pc);
        issue(4'hF, 32'h1234, 32'h1234, pc);
        drain("basic_drain");

        // Shifts: sign replication, ignored upper shamt bits, zero shamt
        issue(ALU_SHIFT_R_A, 32'h8000_0000, 32'd4, pc);
        drain("sra_drain");
        issue(ALU_SHIFT_L_L, 32'h0000_0003, 32'h21, pc);
        drain("sll_drain");
        issue(ALU_SHIFT_R_A, 32'hDEAD_BEEF, 32'h0, pc);
        issue(ALU_SHIFT_L_L, 32'h1234_5678, 32'h20, pc);
        drain("shamt0_drain");

        // Backpressure: result must hold while out_ready is low
        ready_mode = 0;
        @(posedge clk);
        #1;
        issue(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, pc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("bp_result", alu_result, 32'h0000_FF00);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        ready_mode = 1;
        drain("bp_drain");

        // Back-to-back: accept in DONE while the old result retires
        @(posedge clk);
        #1;
        issue(ALU_ADD, 32'd10, 32'd20, p1);
        issue(ALU_OR, 32'h1, 32'h2, p2);
        chk("b2b_accept_gap", 32'(p2 - p1), 32'd1);
        drain("b2b_drain");

        // Reset in the middle of a long shift abandons it
        ready_mode = 0;
        @(posedge clk);
        #1;
        issue(ALU_SHIFT_R_A, 32'h8000_0000, 32'd20, pc);
        repeat (3) @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        sbq.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_alu_result", alu_result, 32'd0);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        mon_en = 1'b1;

        // Randomized traffic with random backpressure and idle gaps
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            f = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) b = a;
            issue(f, a, b, pc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 1;
        drain("random_drain");

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exu_alu_core.md
Name: exu_alu_core

Overview:
- Downstream of the ALU operand-select stage; consumes its alu_a, alu_b and alu_funct outputs and produces alu_result.
- Multi-cycle ALU with valid/ready handshakes on input and output.
- Logic, arithmetic and compare ops take 1 cycle.
- Shifts run iteratively, one bit per cycle, to save area. A barrel option is available (see Optional Feature).
- alu_result feeds writeback, the branch decision and the LSU address path.

Parameters:
- WIDTH, 32, datapath width; equals ISA_WIDTH.
- FUNCT_WIDTH, 4, width of the alu_funct code; equals ALU_FUNCT_WIDTH.
- SHAMT_WIDTH, 5, shift-amount bits taken from alu_b[SHAMT_WIDTH-1:0]; must equal log2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  core can accept operands.
- alu_a  input  WIDTH  operand A.
- alu_b  input  WIDTH  operand B, or shift amount in its low bits.
- alu_funct  input  FUNCT_WIDTH  operation code, using the shared ALU funct codes.
- out_valid  output  1  alu_result valid.
- out_ready  input  1  consumer accepts the result.
- alu_result  output  WIDTH  registered result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, takes effect asynchronously):
  - state=IDLE; out_valid=0; alu_result=0; busy=0; in_ready=1; internal shift counter and operand registers cleared.
  - Reset asserted mid-shift or in DONE abandons the operation; no result is ever presented.
- Input handshake: a transfer occurs on a rising edge where in_valid && in_ready. Operands and funct are captured at that edge. Inputs are don't-care otherwise.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- States:
  - IDLE: on accept of a non-shift funct, compute, register the result and go to DONE. Latency is 1 cycle: out_valid is high in the cycle after acceptance.
  - IDLE: on accept of SHIFT_L_L or SHIFT_R_A:
    - load acc=alu_a and cnt=alu_b[SHAMT_WIDTH-1:0].
    - go to SHIFT if cnt!=0. If cnt==0, set alu_result=alu_a and go to DONE directly (latency 1).
  - SHIFT: each cycle:
    - SHIFT_L_L: acc <<= 1, zero fill.
    - SHIFT_R_A: acc >>= 1, replicating the sign bit.
    - cnt decrements by 1. When cnt reaches 1 (the last shift), alu_result gets the shifted acc and the state goes to DONE.
    - Total latency is shamt+1 cycles. Input is not accepted.
  - DONE: out_valid=1 and alu_result is held stable until out_ready.
    - On out_ready: if a new input is accepted in the same cycle, behave as IDLE-accept; otherwise go to IDLE.
- Simultaneous output-accept and input-accept in DONE: the old result completes and the new op starts with no bubble.
- Arithmetic (all modulo 2^WIDTH, no exceptions):
  - ADD = a+b; SUB = a-b.
  - AND, OR, XOR: bitwise.
  - EQ = {0.., a==b}; NEQ = {0.., a!=b}.
  - LESS_U = {0.., a<b unsigned}.
  - NO_FUNCT and any undefined code give 0 with 1-cycle latency.
- Shift amounts use only the low SHAMT_WIDTH bits of b. Upper bits are ignored: b=33 shifts by 1.
- alu_result changes only on the cycle out_valid rises. It is stable while out_valid && !out_ready.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts are computed combinationally at acceptance with 1-cycle latency, like the other ops. The SHIFT state and counter are not instantiated; busy is high only in DONE.
- Undefined: iterative shifting as described above.

Decomposition:
- Shared header (inst.vh / config.vh, included by this block):
  - the ALU funct codes (ADD, SUB, EQ, NEQ, LESS_U, AND, OR, XOR, SHIFT_L_L, SHIFT_R_A, NO_FUNCT);
  - ALU_FUNCT_WIDTH and ISA_WIDTH;
  - the new state encodings ALU_ST_IDLE, ALU_ST_SHIFT, ALU_ST_DONE and ALU_STATE_WIDTH=2.
- One sub-module: exu_alu_shifter.
  - Holds acc and cnt with load/step/done signals.
  - Becomes a combinational barrel shifter under ALU_BARREL_SHIFT_EN.

Test Plan:
- Reset/idle: hold rst=0, then release → out_valid=0, alu_result=0, in_ready=1, busy=0. Assert rst mid-SHIFT → out_valid stays 0 and state returns to IDLE.
- Basic ops, out_ready=1:
  - ADD a=0xFFFFFFFF, b=1 → 0x00000000 after 1 cycle.
  - SUB 5-7 → 0xFFFFFFFE.
  - LESS_U a=1, b=0xFFFFFFFF → 1.
  - EQ 3,3 → 1; NEQ 3,3 → 0.
- Iterative shift:
  - SHIFT_R_A a=0x80000000, b=4 → 0xF8000000, out_valid exactly 5 cycles after accept; in_ready=0 meanwhile.
  - SHIFT_L_L b=0x21 → shift by 1.
  - shamt=0 → a returned after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after XOR 0xF0F0,0x0FF0 → alu_result=0xFF00 stable and in_ready=0; release → handshake completes.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (OR 0x1,0x2) → first result retires and 0x3 is presented the next cycle with no bubble.
- Unknown funct code 0xF with a=b=0x1234 → result 0, latency 1. Repeat shift cases with ALU_BARREL_SHIFT_EN defined → latency 1.
